ps2_host_ctrl: RTL and testbench

//  Host-side command sequencer between the byte-level PS/2 transceiver and the scancode decoder.
//  - Resets the keyboard and waits for its self-test result.
//  - Keeps keyboard LEDs in sync with led_state.
//  - Handles ACK, RESEND and timeout retries.
//  - Forwards every non-protocol received byte to the decoder unchanged.

---
 rtl/ps2_host_ctrl_pkg.sv | 28 ++
 rtl/ps2_host_ctrl_ms_timer.sv | 38 +++
 rtl/ps2_host_ctrl.sv | 153 +++++++++++++++
 tb/tb_ps2_host_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_host_ctrl_pkg.sv
// Shared PS/2 command/response codes and the host sequencer state encoding.
package ps2_host_ctrl_pkg;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LED  = 8'hED;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [3:0] {
    StInitTx,
    StInitAck,
    StInitBat,
    StIdle,
    StLedTxCmd,
    StLedAckCmd,
    StLedTxVal,
    StLedAckVal,
    StFault
  } state_e;

  function automatic logic is_protocol_byte(input logic [7:0] b);
    return (b == PS2_RSP_ACK) || (b == PS2_RSP_RESEND) ||
           (b == PS2_RSP_BAT_OK) || (b == PS2_RSP_BAT_FAIL);
  endfunction

endpackage

// File: rtl/ps2_host_ctrl_ms_timer.sv
// Millisecond timer: clk prescaler feeding a saturating ms counter, both synchronously clearable.
module ps2_host_ctrl_ms_timer #(
  parameter int unsigned CLK_FREQ = 28000000,
  parameter int unsigned SAT_MS   = 1000,
  parameter int unsigned MsW      = $clog2(SAT_MS + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear_i,
  output logic [MsW-1:0] ms_o
);

  localparam int unsigned TicksPerMs = CLK_FREQ / 1000;
  localparam int unsigned PreW       = (TicksPerMs > 1) ? $clog2(TicksPerMs) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(TicksPerMs - 1);
  localparam logic [MsW-1:0]  MsSat  = MsW'(SAT_MS);

  logic [PreW-1:0] pre_q;
  logic [MsW-1:0]  ms_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else if (clear_i) begin
      pre_q <= '0;
      ms_q  <= '0;
    end else if (pre_q == PreMax) begin
      pre_q <= '0;
      if (ms_q != MsSat) ms_q <= ms_q + MsW'(1);
    end else begin
      pre_q <= pre_q + PreW'(1);
    end
  end

  assign ms_o = ms_q;

endmodule

// File: rtl/ps2_host_ctrl.sv
// PS/2 host command sequencer: keyboard reset/BAT, LED sync, ACK/RESEND/timeout retries,
// and forwarding of non-protocol bytes to the scancode decoder.
module ps2_host_ctrl
  import ps2_host_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 28000000,
  parameter int unsigned ACK_TIMEOUT_MS = 20,
  parameter int unsigned BAT_TIMEOUT_MS = 1000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_byte_i,
  input  logic       rx_valid_i,
  input  logic       rx_error_i,
  output logic [7:0] tx_byte_o,
  output logic       tx_start_o,
  input  logic       tx_busy_i,
  input  logic       tx_error_i,
  input  logic [2:0] led_state_i,
  input  logic       init_req_i,
  output logic [7:0] scan_byte_o,
  output logic       scan_valid_o,
  output logic       kbd_ready_o,
  output logic       kbd_fault_o
);

  localparam int unsigned MsW    = $clog2(BAT_TIMEOUT_MS + 1);
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  state_e              state_q, state_prev_q;
  logic [7:0]          tx_byte_q, scan_byte_q;
  logic                tx_start_q, scan_valid_q, kbd_ready_q, kbd_fault_q;
  logic [2:0]          led_sent_q;
  logic [RetryW-1:0]   retry_q;
  logic [MsW-1:0]      ms;
  logic                tmr_clr;

  // Clear lands in the first cycle of a new state or right after a tx_start, so the ms
  // value seen in that cycle is stale and must not trigger a timeout.
  assign tmr_clr = tx_start_q || (state_q != state_prev_q);

  ps2_host_ctrl_ms_timer #(
    .CLK_FREQ (CLK_FREQ),
    .SAT_MS   (BAT_TIMEOUT_MS),
    .MsW      (MsW)
  ) u_ms_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (tmr_clr),
    .ms_o    (ms)
  );

  logic   rx_ack, rx_bat_ok, ack_state, fail_evt, consumed;
  state_e retry_st, ack_next_st;

  always_comb begin
    rx_ack      = rx_valid_i && (rx_byte_i == PS2_RSP_ACK);
    rx_bat_ok   = rx_valid_i && (rx_byte_i == PS2_RSP_BAT_OK);
    ack_state   = (state_q == StInitAck) || (state_q == StLedAckCmd) || (state_q == StLedAckVal);
    retry_st    = StInitTx;
    ack_next_st = StInitBat;
    case (state_q)
      StLedAckCmd: begin retry_st = StLedTxCmd; ack_next_st = StLedTxVal; end
      StLedAckVal: begin retry_st = StLedTxVal; ack_next_st = StIdle;     end
      default:     ;
    endcase
    fail_evt = 1'b0;
    if (ack_state) begin
      fail_evt = !rx_ack && ((rx_valid_i && (rx_byte_i == PS2_RSP_RESEND)) || tx_error_i ||
                 rx_error_i || (!tmr_clr && (ms >= MsW'(ACK_TIMEOUT_MS))));
    end else if (state_q == StInitBat) begin
      fail_evt = !rx_bat_ok && ((rx_valid_i && (rx_byte_i == PS2_RSP_BAT_FAIL)) ||
                 (!tmr_clr && (ms >= MsW'(BAT_TIMEOUT_MS))));
    end
    consumed = rx_valid_i && (ack_state || (state_q == StInitBat)) && is_protocol_byte(rx_byte_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StInitTx;
      state_prev_q <= StInitTx;
      tx_byte_q    <= '0;
      tx_start_q   <= 1'b0;
      scan_byte_q  <= '0;
      scan_valid_q <= 1'b0;
      kbd_ready_q  <= 1'b0;
      kbd_fault_q  <= 1'b0;
      led_sent_q   <= '0;
      retry_q      <= '0;
    end else begin
      tx_start_q   <= 1'b0;
      state_prev_q <= state_q;
      scan_valid_q <= rx_valid_i && !consumed;
      if (rx_valid_i && !consumed) scan_byte_q <= rx_byte_i;

      if (init_req_i) begin
        kbd_ready_q <= 1'b0;
        kbd_fault_q <= 1'b0;
        retry_q     <= '0;
        state_q     <= StInitTx;
      end else if (fail_evt) begin
        if (retry_q == RetryW'(MAX_RETRY)) begin
          kbd_ready_q <= 1'b0;
          kbd_fault_q <= 1'b1;
          state_q     <= StFault;
        end else begin
          retry_q <= retry_q + RetryW'(1);
          state_q <= retry_st;
        end
      end else begin
        case (state_q)
          StInitTx: if (!tx_busy_i) begin
            tx_byte_q  <= PS2_CMD_RESET;
            tx_start_q <= 1'b1;
            state_q    <= StInitAck;
          end
          StLedTxCmd: if (!tx_busy_i) begin
            tx_byte_q  <= PS2_CMD_SET_LED;
            tx_start_q <= 1'b1;
            state_q    <= StLedAckCmd;
          end
          StLedTxVal: if (!tx_busy_i) begin
            tx_byte_q  <= {5'b0, led_state_i};
            led_sent_q <= led_state_i;
            tx_start_q <= 1'b1;
            state_q    <= StLedAckVal;
          end
          StInitAck, StLedAckCmd, StLedAckVal: if (rx_ack) begin
            retry_q <= '0;
            state_q <= ack_next_st;
          end
          StInitBat: if (rx_bat_ok) begin
            retry_q     <= '0;
            kbd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
          StIdle: if ((led_state_i != led_sent_q) && kbd_ready_q) state_q <= StLedTxCmd;
          StFault: ;
          default: state_q <= StInitTx;
        endcase
      end
    end
  end

  assign tx_byte_o    = tx_byte_q;
  assign tx_start_o   = tx_start_q;
  assign scan_byte_o  = scan_byte_q;
  assign scan_valid_o = scan_valid_q;
  assign kbd_ready_o  = kbd_ready_q;
  assign kbd_fault_o  = kbd_fault_q;

endmodule

// File: tb/tb_ps2_host_ctrl.sv
// Directed bench for ps2_host_ctrl with tx/scan scoreboards and a simple transceiver model.
module tb_ps2_host_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_error, tx_busy, tx_error, init_req;
  logic [2:0] led_state;
  logic [7:0] tx_byte, scan_byte;
  logic       tx_start, scan_valid, kbd_ready, kbd_fault;

  int         n_vec = 0;
  int         n_err = 0;
  int         tx_cnt = 0;
  int         scan_cnt = 0;
  int         cyc = 0;
  int         busy_cnt = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_scan[$];
  int         tx_t[$];

  always #5 clk = ~clk;

  ps2_host_ctrl #(
    .CLK_FREQ       (10000),
    .ACK_TIMEOUT_MS (20),
    .BAT_TIMEOUT_MS (1000),
    .MAX_RETRY      (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_byte_i    (rx_byte),
    .rx_valid_i   (rx_valid),
    .rx_error_i   (rx_error),
    .tx_byte_o    (tx_byte),
    .tx_start_o   (tx_start),
    .tx_busy_i    (tx_busy),
    .tx_error_i   (tx_error),
    .led_state_i  (led_state),
    .init_req_i   (init_req),
    .scan_byte_o  (scan_byte),
    .scan_valid_o (scan_valid),
    .kbd_ready_o  (kbd_ready),
    .kbd_fault_o  (kbd_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Transceiver model: busy for 8 clocks after each tx_start.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) busy_cnt <= 0;
    else if (tx_start) busy_cnt <= 8;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  always @(negedge clk) begin
    if (rst_n && tx_start === 1'b1) begin
      tx_cnt++;
      tx_t.push_back(cyc);
      if (exp_tx.size() == 0) chk("tx_unexpected", {24'h0, tx_byte}, 32'h100);
      else chk("tx_byte", {24'h0, tx_byte}, {24'h0, exp_tx.pop_front()});
    end
    if (rst_n && scan_valid === 1'b1) begin
      scan_cnt++;
      if (exp_scan.size() == 0) chk("scan_unexpected", {24'h0, scan_byte}, 32'h100);
      else chk("scan_byte", {24'h0, scan_byte}, {24'h0, exp_scan.pop_front()});
    end
  end

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Keyboard answers only once the host has released the line.
  task automatic reply(input logic [7:0] b);
    int n = 0;
    while (tx_busy && n < 100) begin @(negedge clk); n++; end
    chk("busy_release", {31'h0, tx_busy}, 32'h0);
    repeat (3) @(negedge clk);
    send_rx(b);
  endtask

  task automatic wait_tx(input int target, input int budget);
    int n = 0;
    while (tx_cnt < target && n < budget) begin @(negedge clk); n++; end
    @(negedge clk);
    chk("tx_wait", tx_cnt, target);
  endtask

  task automatic pulse_init;
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst_n = 1'b0; rx_byte = '0; rx_valid = 1'b0; rx_error = 1'b0;
    tx_error = 1'b0; led_state = 3'b000; init_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx_byte", {24'h0, tx_byte}, 32'h0);
    chk("rst_tx_start", {31'h0, tx_start}, 32'h0);
    chk("rst_scan_byte", {24'h0, scan_byte}, 32'h0);
    chk("rst_scan_valid", {31'h0, scan_valid}, 32'h0);
    chk("rst_ready", {31'h0, kbd_ready}, 32'h0);
    chk("rst_fault", {31'h0, kbd_fault}, 32'h0);

    // Power-up: reset command, ACK, BAT OK.
    exp_tx.push_back(8'hFF);
    rst_n = 1'b1;
    wait_tx(1, 100);
    reply(8'hFA);
    repeat (5) @(negedge clk);
    chk("ready_before_bat", {31'h0, kbd_ready}, 32'h0);
    reply(8'hAA);
    chk("ready_after_bat", {31'h0, kbd_ready}, 32'h1);
    repeat (20) @(negedge clk);
    chk("init_no_scan", scan_cnt, 0);
    chk("init_single_tx", tx_cnt, 1);

    // LED update 000 -> 100.
    led_state = 3'b100;
    exp_tx.push_back(8'hED);
    wait_tx(2, 100);
    reply(8'hFA);
    exp_tx.push_back(8'h04);
    wait_tx(3, 100);
    reply(8'hFA);
    repeat (300) @(negedge clk);
    chk("led_idle_no_tx", tx_cnt, 3);

    // Two RESENDs on the LED command, then ACK.
    led_state = 3'b010;
    exp_tx.push_back(8'hED);
    wait_tx(4, 100);
    reply(8'hFE);
    exp_tx.push_back(8'hED);
    wait_tx(5, 100);
    reply(8'hFE);
    exp_tx.push_back(8'hED);
    wait_tx(6, 100);
    reply(8'hFA);
    exp_tx.push_back(8'h02);
    wait_tx(7, 100);
    reply(8'hFA);
    repeat (20) @(negedge clk);
    chk("resend_no_fault", {31'h0, kbd_fault}, 32'h0);
    chk("resend_ready", {31'h0, kbd_ready}, 32'h1);

    // rx_error in IDLE: nothing happens.
    @(negedge clk); rx_error = 1'b1;
    @(negedge clk); rx_error = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_rxerr_no_tx", tx_cnt, 7);

    // Key byte between 0xED and its ACK is forwarded, the ACK is not.
    led_state = 3'b011;
    exp_tx.push_back(8'hED);
    wait_tx(8, 100);
    exp_scan.push_back(8'h1C);
    reply(8'h1C);
    chk("fwd_valid_timing", {31'h0, scan_valid}, 32'h1);
    chk("fwd_byte_timing", {24'h0, scan_byte}, 32'h1C);
    reply(8'hFA);
    exp_tx.push_back(8'h03);
    wait_tx(9, 100);
    reply(8'hFA);
    repeat (10) @(negedge clk);
    chk("fwd_scan_count", scan_cnt, 1);

    // init_req while waiting for the LED value ACK.
    led_state = 3'b111;
    exp_tx.push_back(8'hED);
    wait_tx(10, 100);
    reply(8'hFA);
    exp_tx.push_back(8'h07);
    wait_tx(11, 100);
    exp_tx.push_back(8'hFF);
    pulse_init;
    chk("initreq_ready_clr", {31'h0, kbd_ready}, 32'h0);
    wait_tx(12, 100);
    reply(8'hFA);
    repeat (5) @(negedge clk);
    chk("initreq_ready_wait", {31'h0, kbd_ready}, 32'h0);
    reply(8'hAA);
    chk("initreq_ready_set", {31'h0, kbd_ready}, 32'h1);
    repeat (30) @(negedge clk);
    chk("initreq_no_led_tx", tx_cnt, 12);

    // Silent keyboard: 4 resets 20 ms apart, then FAULT.
    base = tx_cnt;
    repeat (4) exp_tx.push_back(8'hFF);
    pulse_init;
    wait_tx(base + 4, 1500);
    for (int k = 1; k < 4; k++) begin
      if (tx_t.size() > base + k) begin
        int d;
        d = tx_t[base + k] - tx_t[base + k - 1];
        chk("timeout_spacing", {31'h0, (d >= 200 && d <= 210)}, 32'h1);
      end
    end
    chk("pre_fault_clear", {31'h0, kbd_fault}, 32'h0);
    repeat (260) @(negedge clk);
    chk("fault_set", {31'h0, kbd_fault}, 32'h1);
    chk("fault_not_ready", {31'h0, kbd_ready}, 32'h0);
    chk("fault_no_tx", tx_cnt, base + 4);

    // In FAULT even protocol bytes are forwarded.
    exp_scan.push_back(8'hFA);
    send_rx(8'hFA);
    chk("fault_fwd_valid", {31'h0, scan_valid}, 32'h1);
    chk("fault_fwd_byte", {24'h0, scan_byte}, 32'hFA);

    // init_req clears the sticky fault and restarts.
    exp_tx.push_back(8'hFF);
    pulse_init;
    chk("fault_cleared", {31'h0, kbd_fault}, 32'h0);
    wait_tx(base + 5, 100);
    repeat (5) @(negedge clk);
    chk("exp_tx_drained", exp_tx.size(), 0);
    chk("exp_scan_drained", exp_scan.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
